gcounter_seq_ctrl: RTL and testbench
====================================

// Module: gcounter_seq_ctrl
// PURPOSE
//  Sequencer for the low-power gated counter in the power-measurement datapath.
//  Clears the counter, enables it for a programmed count window, and watches for stop, stall or overshoot.
//  Returns the final count through a valid/ready result port.
//  Sits between the host/testbench control logic and one gcounter instance (drives its enable/clear, reads q).
// PARAMETERS
//  WIDTH          32   counter / limit / result width in bits
//  DEFAULT_LIMIT  100  limit_r value after reset
//  STALL_MAX      16   consecutive RUN cycles with unchanged cnt_q that flag a stall (>=2)
// PORTS
//  clk         in   1      clock
//  reset       in   1      reset, synchronous, active-high
//  cfg_we      in   1      load cfg_limit into limit_r; honoured only in IDLE
//  cfg_limit   in   WIDTH  terminal count for next run
//  start       in   1      begin run; honoured only in IDLE
//  stop        in   1      early stop request; honoured only in RUN
//  abort       in   1      return to IDLE from any state, result discarded
//  cnt_clr     out  1      counter clear, one-cycle pulse
//  cnt_en      out  1      counter enable
//  cnt_q       in   WIDTH  current counter value (registered, advances <=1 per cycle)
//  busy        out  1      state != IDLE
//  res_valid   out  1      result available
//  res_ready   in   1      result accepted
//  res_data    out  WIDTH  captured count
//  res_status  out  2      00 limit hit, 01 stopped, 10 stall, 11 overshoot
// BEHAVIOUR
//  Reset: state=IDLE, limit_r=DEFAULT_LIMIT, stall_cnt=0; cnt_clr=cnt_en=busy=res_valid=0, res_data=0, res_status=00.
//   Reset mid-run returns to IDLE at the next edge; no cnt_clr is emitted.
//  States: IDLE -> CLEAR -> RUN -> HOLD -> IDLE.
//  IDLE:
//   - cfg_we: limit_r<=cfg_limit.
//   - start: ->CLEAR. If cfg_we and start arrive together, the new limit applies.
//  CLEAR (1 cycle): cnt_clr=1, cnt_en=0; ->RUN unconditionally.
//  RUN: cnt_en = !(cnt_q>=limit_r) && !stop && !stall_hit (combinational).
//   Exit conditions, in priority order; exit to HOLD at the next edge:
//   a) cnt_q==limit_r -> status 00
//   b) cnt_q>limit_r (unsigned) -> status 11
//   c) stall_cnt==STALL_MAX-1 with cnt_q unchanged from the previous cycle -> status 10
//   d) stop -> status 01
//   On exit: res_data<=cnt_q of that cycle, res_status<=code.
//  Stall counter:
//   - stall_cnt increments each RUN cycle in which cnt_q equals the previous cycle's cnt_q.
//   - It clears on any change of cnt_q and on entry to RUN.
//   - The first RUN cycle has no previous cnt_q, so it counts as changed.
//  Limit 0: first RUN cycle sees cnt_q==0 -> HOLD with res_data=0, status 00; cnt_en never asserted.
//  HOLD:
//   - res_valid=1; res_data and res_status stay stable until the handshake.
//   - res_valid&&res_ready -> IDLE at the next edge; res_valid drops in IDLE.
//   - start, stop, cfg_we ignored.
//  abort: highest priority in every state; ->IDLE next edge, res_valid=0, cnt_en=0 in that cycle.
//   abort+start in IDLE: stays IDLE.
//  Latency: start edge -> cnt_clr 1 cycle later -> first cnt_en 2 cycles after start.
//   Terminal cnt_q -> res_valid 1 cycle later.
//  WIDTH arithmetic is unsigned; no wrap: limit 2^WIDTH-1 is valid, and cnt_q wrap to 0 counts as a change.
// TESTING
//  1. limit=5, start, counter model +1 every 2nd enabled cycle -> res_valid with res_data=5, status 00; cnt_en low from cnt_q=5.
//  2. limit=0, start -> one cnt_clr, no cnt_en; HOLD 2 cycles after start with data 0, status 00.
//  3. limit=1000, stop at cnt_q=37 -> res_data=37, status 01; res_ready held low 10 cycles -> data stable, then IDLE.
//  4. Counter model frozen at 3, STALL_MAX=16 -> status 10, res_data=3 after 16 unchanged RUN cycles.
//  5. Model jumps cnt_q 8->12 with limit=10 -> status 11, res_data=12; abort in RUN and HOLD -> IDLE next cycle, busy=0.
//  6. cfg_we during RUN ignored (next run uses old limit); reset asserted mid-RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/gcounter_seq_ctrl.sv
// Sequencer for the gated power-measurement counter: clears it, enables it for a
// programmed window, detects limit/stop/stall/overshoot and returns the final count.
module gcounter_seq_ctrl #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned DEFAULT_LIMIT = 100,
  parameter int unsigned STALL_MAX     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             start,
  input  logic             stop,
  input  logic             abort,
  output logic             cnt_clr,
  output logic             cnt_en,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       res_status
);

  localparam int unsigned SW = (STALL_MAX > 2) ? $clog2(STALL_MAX) : 1;

  localparam logic [1:0] ST_LIMIT = 2'b00;
  localparam logic [1:0] ST_STOP  = 2'b01;
  localparam logic [1:0] ST_STALL = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] limit_r;
  logic [WIDTH-1:0] prev_q;
  logic [SW-1:0]    stall_cnt;
  logic             first_run;
  logic             clr_r;
  logic             busy_r;
  logic             hold_r;

  logic             same_q_c;
  logic             stall_hit_c;
  logic             exit_c;
  logic [1:0]       code_c;

  // The first RUN cycle has no valid previous sample, so it always counts as a change.
  assign same_q_c    = !first_run && (cnt_q == prev_q);
  assign stall_hit_c = same_q_c && (stall_cnt == SW'(STALL_MAX - 1));

  assign cnt_en    = (state == RUN) && !abort && (cnt_q < limit_r) && !stop && !stall_hit_c;
  assign cnt_clr   = clr_r;
  assign busy      = busy_r;
  assign res_valid = hold_r && !abort;

  // RUN exit decision in priority order: limit, overshoot, stall, stop.
  always_comb begin
    exit_c = 1'b0;
    code_c = ST_LIMIT;
    if (state == RUN) begin
      if (cnt_q == limit_r) begin
        exit_c = 1'b1;
        code_c = ST_LIMIT;
      end else if (cnt_q > limit_r) begin
        exit_c = 1'b1;
        code_c = ST_OVER;
      end else if (stall_hit_c) begin
        exit_c = 1'b1;
        code_c = ST_STALL;
      end else if (stop) begin
        exit_c = 1'b1;
        code_c = ST_STOP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      limit_r    <= WIDTH'(DEFAULT_LIMIT);
      prev_q     <= '0;
      stall_cnt  <= '0;
      first_run  <= 1'b0;
      clr_r      <= 1'b0;
      busy_r     <= 1'b0;
      hold_r     <= 1'b0;
      res_data   <= '0;
      res_status <= ST_LIMIT;
    end else begin
      prev_q    <= cnt_q;
      first_run <= 1'b0;
      clr_r     <= 1'b0;
      if (abort) begin
        state  <= IDLE;
        busy_r <= 1'b0;
        hold_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_we) limit_r <= cfg_limit;
            if (start) begin
              state  <= CLEAR;
              clr_r  <= 1'b1;
              busy_r <= 1'b1;
            end
          end
          CLEAR: begin
            state     <= RUN;
            first_run <= 1'b1;
            stall_cnt <= '0;
          end
          RUN: begin
            if (same_q_c) stall_cnt <= stall_cnt + SW'(1);
            else          stall_cnt <= '0;
            if (exit_c) begin
              state      <= HOLD;
              hold_r     <= 1'b1;
              res_data   <= cnt_q;
              res_status <= code_c;
            end
          end
          HOLD: begin
            if (res_ready) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              hold_r <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            busy_r <= 1'b0;
            hold_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gcounter_seq_ctrl.sv
// Scoreboard bench for gcounter_seq_ctrl with a behavioural gated-counter model.
module tb_gcounter_seq_ctrl;

  localparam int unsigned WIDTH = 32;

  localparam int M_HALF   = 0;
  localparam int M_FULL   = 1;
  localparam int M_FROZEN = 2;
  localparam int M_JUMP   = 3;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [1:0]       status;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_limit;
  logic             start;
  logic             stop;
  logic             abort;
  logic             cnt_clr;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_q;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [1:0]       res_status;

  exp_t             exp_q[$];
  int               checks;
  int               errors;
  int               mode;
  logic             half_tgl;
  logic [WIDTH-1:0] cur_limit;

  gcounter_seq_ctrl #(.WIDTH(WIDTH), .DEFAULT_LIMIT(100), .STALL_MAX(16)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_limit(cfg_limit),
    .start(start), .stop(stop), .abort(abort), .cnt_clr(cnt_clr),
    .cnt_en(cnt_en), .cnt_q(cnt_q), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_status(res_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gated counter model with selectable behaviour.
  always @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      half_tgl <= 1'b0;
    end else if (mode == M_FROZEN) begin
      cnt_q <= 32'd3;
    end else if (cnt_clr) begin
      cnt_q    <= '0;
      half_tgl <= 1'b0;
    end else if (cnt_en) begin
      case (mode)
        M_HALF: begin
          half_tgl <= ~half_tgl;
          if (half_tgl) cnt_q <= cnt_q + 32'd1;
        end
        M_JUMP:  cnt_q <= (cnt_q == 32'd8) ? 32'd12 : cnt_q + 32'd1;
        default: cnt_q <= cnt_q + 32'd1;
      endcase
    end
  end

  // Result monitor: pops the scoreboard on each accepted result.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got data=%0d status=%b with empty scoreboard", res_data, res_status);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (res_data !== e.data || res_status !== e.status) begin
          errors++;
          $display("FAIL result: got data=%0d status=%b, expected data=%0d status=%b",
                   res_data, res_status, e.data, e.status);
        end
      end
    end
  end

  // Enable must stay low whenever the counter is at or past the limit.
  always @(negedge clk) begin
    if (!reset && busy && cnt_q >= cur_limit) begin
      checks++;
      if (cnt_en !== 1'b0) begin
        errors++;
        $display("FAIL en_at_limit: cnt_en=%b with cnt_q=%0d limit=%0d", cnt_en, cnt_q, cur_limit);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_cfg(input logic [WIDTH-1:0] lim);
    cfg_we    = 1'b1;
    cfg_limit = lim;
    tick();
    cfg_we    = 1'b0;
    cur_limit = lim;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic [1:0] s);
    exp_t e;
    e.data   = d;
    e.status = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, budget);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"},   64'(busy), 64'd0);
    chk({name, "_clr"},    64'(cnt_clr), 64'd0);
    chk({name, "_en"},     64'(cnt_en), 64'd0);
    chk({name, "_valid"},  64'(res_valid), 64'd0);
    chk({name, "_data"},   64'(res_data), 64'd0);
    chk({name, "_status"}, 64'(res_status), 64'd0);
  endtask

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    mode      = M_HALF;
    cur_limit = 32'd100;
    reset     = 1'b1;
    cfg_we    = 1'b0;
    cfg_limit = '0;
    start     = 1'b0;
    stop      = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b1;
    tick();
    tick();
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // 1: limit 5, counter advancing every second enabled cycle
    mode = M_HALF;
    do_cfg(32'd5);
    push(32'd5, 2'b00);
    do_start();
    wait_idle("t1", 100);

    // 2: limit 0, clear pulse only, HOLD two edges after start
    do_cfg(32'd0);
    push(32'd0, 2'b00);
    do_start();
    chk("t2_clr", 64'(cnt_clr), 64'd1);
    chk("t2_en_clear", 64'(cnt_en), 64'd0);
    chk("t2_valid_early", 64'(res_valid), 64'd0);
    tick();
    chk("t2_clr_run", 64'(cnt_clr), 64'd0);
    chk("t2_en_run", 64'(cnt_en), 64'd0);
    chk("t2_valid_run", 64'(res_valid), 64'd0);
    tick();
    chk("t2_valid_hold", 64'(res_valid), 64'd1);
    chk("t2_data_hold", 64'(res_data), 64'd0);
    wait_idle("t2", 10);

    // 3: early stop at 37, result held with res_ready low
    mode = M_FULL;
    do_cfg(32'd1000);
    res_ready = 1'b0;
    push(32'd37, 2'b01);
    do_start();
    n = 0;
    while (cnt_q != 32'd37 && n < 200) begin
      tick();
      n++;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t3_valid", 64'(res_valid), 64'd1);
      chk("t3_data", 64'(res_data), 64'd37);
      chk("t3_status", 64'(res_status), 64'd1);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("t3_idle", 64'(busy), 64'd0);

    // 4: frozen counter -> stall after 16 unchanged RUN cycles
    mode = M_FROZEN;
    push(32'd3, 2'b10);
    do_start();
    n = 0;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    chk("t4_latency", 64'(n), 64'd18);
    wait_idle("t4", 10);

    // 5: overshoot 8->12 past limit 10, then aborts
    mode = M_JUMP;
    do_cfg(32'd10);
    push(32'd12, 2'b11);
    do_start();
    wait_idle("t5", 100);
    mode = M_FULL;
    do_cfg(32'd1000);
    do_start();
    repeat (5) tick();
    abort = 1'b1;
    #1;
    chk("t5_abort_run_en", 64'(cnt_en), 64'd0);
    tick();
    abort = 1'b0;
    chk("t5_abort_run_busy", 64'(busy), 64'd0);
    res_ready = 1'b0;
    do_cfg(32'd0);
    do_start();
    tick();
    tick();
    chk("t5_hold_valid", 64'(res_valid), 64'd1);
    abort = 1'b1;
    #1;
    chk("t5_abort_hold_valid", 64'(res_valid), 64'd0);
    tick();
    abort = 1'b0;
    res_ready = 1'b1;
    chk("t5_abort_hold_busy", 64'(busy), 64'd0);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("t5_abort_start_idle", 64'(busy), 64'd0);

    // 6: cfg_we with start applies, cfg_we in RUN ignored, reset mid-run
    cfg_we    = 1'b1;
    cfg_limit = 32'd4;
    start     = 1'b1;
    tick();
    cfg_we    = 1'b0;
    start     = 1'b0;
    cur_limit = 32'd4;
    push(32'd4, 2'b00);
    tick();
    cfg_we    = 1'b1;
    cfg_limit = 32'd7;
    tick();
    cfg_we    = 1'b0;
    wait_idle("t6a", 50);
    push(32'd4, 2'b00);
    do_start();
    wait_idle("t6b", 50);
    do_cfg(32'd1000);
    do_start();
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk_reset_outputs("t6_midreset");
    reset     = 1'b0;
    cur_limit = 32'd100;
    push(32'd100, 2'b00);
    do_start();
    wait_idle("t6_default", 300);

    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
